// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder.
//   - cla_nstage      : number of pipeline stages for a given configuration
//   - lookahead_carry : sum-of-products carry into position n of a
//                       generate/propagate vector (no ripple chain)
//   - stage_ctrl_t    : control part of one stage's pipeline register
//                       (valid, carry into the next stage, sub flag)
// Optional feature macro: CLA_ADDER_SUB_EN (adds the sub flag to the struct).
// -----------------------------------------------------------------------------
package cla_pkg;

    // Widest generate/propagate vector the lookahead helper accepts.
    localparam int LA_W = 32;

    function automatic int cla_nstage(input int width, input int block, input int gps);
        return (width + block * gps - 1) / (block * gps);
    endfunction

    // Carry into position n: c0 & p[0..n-1]  |  OR_j ( g[j] & p[j+1..n-1] ).
    // Written as a flat sum of products so every carry is two logic levels
    // deep in g/p rather than a chain through the lower carries.
    function automatic logic lookahead_carry(input logic [LA_W-1:0] g,
                                             input logic [LA_W-1:0] p,
                                             input logic            c0,
                                             input int              n);
        logic carry;
        logic term;
        term = c0;
        for (int m = 0; m < n; m++) term = term & p[m];
        carry = term;
        for (int j = 0; j < n; j++) begin
            term = g[j];
            for (int m = j + 1; m < n; m++) term = term & p[m];
            carry = carry | term;
        end
        return carry;
    endfunction

    typedef struct packed {
        logic valid;
        logic carry;
`ifdef CLA_ADDER_SUB_EN
        logic sub;
`endif
    } stage_ctrl_t;

endpackage

// File: rtl/cla_group.sv
// -----------------------------------------------------------------------------
// cla_group
// Combinational BLOCK-bit carry-lookahead group.
// Ports:
//   a, b   in  BLOCK  operand slices
//   ci     in  1      carry into the group LSB
//   s      out BLOCK  sum slice
//   g      out 1      group generate (carry out assuming ci=0)
//   p      out 1      group propagate (all bits propagate)
//   c_msb  out 1      carry into the group MSB (used for signed overflow)
// -----------------------------------------------------------------------------
module cla_group
    import cla_pkg::*;
#(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             g,
    output logic             p,
    output logic             c_msb
);

    logic [BLOCK-1:0] bit_g;
    logic [BLOCK-1:0] bit_p;
    logic [BLOCK-1:0] carry;

    assign bit_g = a & b;
    assign bit_p = a ^ b;

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        carry = '0;
        for (int i = 0; i < BLOCK; i++) begin
            carry[i] = lookahead_carry(LA_W'(bit_g), LA_W'(bit_p), ci, i);
        end
    end

    assign s     = bit_p ^ carry;
    assign g     = lookahead_carry(LA_W'(bit_g), LA_W'(bit_p), 1'b0, BLOCK);
    assign p     = &bit_p;
    assign c_msb = carry[BLOCK-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// cla_adder_pipe
// Pipelined carry-lookahead adder with valid/ready handshakes on both sides.
// Each stage resolves BLOCK*GROUPS_PER_STAGE sum bits with two-level
// lookahead (inside groups, then across the stage's groups) and registers the
// carry for the next stage. Unconsumed operand bits and finished sum bits
// travel alongside in skew registers.
// Ports:
//   clk        in  1      clock, rising edge
//   rst        in  1      asynchronous active-high reset
//   in_valid   in  1      operand beat valid
//   in_ready   out 1      beat accepted this cycle
//   a, b       in  WIDTH  operands
//   ci         in  1      carry in
//   sub        in  1      subtract (only with CLA_ADDER_SUB_EN)
//   out_valid  out 1      result valid
//   out_ready  in  1      downstream accepts result
//   s          out WIDTH  sum
//   co         out 1      carry out of MSB (1 = no borrow when subtracting)
//   of         out 1      signed overflow
// Optional feature macro: CLA_ADDER_SUB_EN.
// -----------------------------------------------------------------------------
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int BLOCK            = 4,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef CLA_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             of
);

    localparam int SW      = BLOCK * GROUPS_PER_STAGE;
    localparam int NSTAGE  = cla_nstage(WIDTH, BLOCK, GROUPS_PER_STAGE);
    localparam int NUM_MID = (NSTAGE > 1) ? NSTAGE - 1 : 1;
    // Stage 0 consumes the low SW operand bits straight from the ports, so
    // only the bits above it ever need to be carried in skew registers.
    localparam int OP_LO   = (NSTAGE > 1) ? SW : 0;

    stage_ctrl_t          ctrl_q [NSTAGE];
    logic [WIDTH-1:0]     sum_q  [NSTAGE];
    logic [WIDTH-1:OP_LO] a_q    [NUM_MID];
    logic [WIDTH-1:OP_LO] b_q    [NUM_MID];
    logic                 of_q;
    logic                 c_into_msb;
    logic [NSTAGE-1:0]    vld;
    logic [NSTAGE-1:0]    adv;

    always_comb begin
        vld = '0;
        for (int k = 0; k < NSTAGE; k++) vld[k] = ctrl_q[k].valid;
    end

    // Stage k may load when any stage from k to the output has a hole, or the
    // output is being taken; the closed form avoids a chain through adv itself.
    for (genvar k = 0; k < NSTAGE; k++) begin : g_adv
        assign adv[k] = out_ready | ~(&vld[NSTAGE-1:k]);
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[NSTAGE-1];
    assign s         = sum_q[NSTAGE-1];
    assign co        = ctrl_q[NSTAGE-1].carry;
    assign of        = of_q;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int LO = k * SW;
        localparam int HI = (LO + SW > WIDTH) ? WIDTH : LO + SW;
        localparam int W  = HI - LO;
        localparam int NG = W / BLOCK;

        logic [W-1:0]     op_a;
        logic [W-1:0]     op_b;
        logic [W-1:0]     op_s;
        logic             c_in;
        logic             v_in;
        logic             flip;
        logic [WIDTH-1:0] sum_prev;
        logic [WIDTH-1:0] sum_d;
        logic [NG-1:0]    grp_g;
        logic [NG-1:0]    grp_p;
        logic [NG:0]      grp_c;
        stage_ctrl_t      ctrl_d;

        if (k == 0) begin : g_src
`ifdef CLA_ADDER_SUB_EN
            assign flip = sub;
            assign c_in = sub | ci;  // subtract forces carry-in to 1
`else
            assign flip = 1'b0;
            assign c_in = ci;
`endif
            assign op_a     = a[HI-1:LO];
            assign v_in     = in_valid;
            assign sum_prev = '0;
        end else begin : g_src
`ifdef CLA_ADDER_SUB_EN
            assign flip = ctrl_q[k-1].sub;
`else
            assign flip = 1'b0;
`endif
            assign c_in     = ctrl_q[k-1].carry;
            assign op_a     = a_q[k-1][HI-1:LO];
            assign v_in     = ctrl_q[k-1].valid;
            assign sum_prev = sum_q[k-1];
        end

        // Each stage inverts its own slice of b, so the raw operand travels
        // and the sub flag is what rides along with the beat.
        if (k == 0) begin : g_opb
            assign op_b = b[HI-1:LO] ^ {W{flip}};
        end else begin : g_opb
            assign op_b = b_q[k-1][HI-1:LO] ^ {W{flip}};
        end

        for (genvar g = 0; g < NG; g++) begin : g_grp
            if (k == NSTAGE - 1 && g == NG - 1) begin : g_top
                cla_group #(.BLOCK(BLOCK)) u_grp (
                    .a     (op_a[g*BLOCK +: BLOCK]),
                    .b     (op_b[g*BLOCK +: BLOCK]),
                    .ci    (grp_c[g]),
                    .s     (op_s[g*BLOCK +: BLOCK]),
                    .g     (grp_g[g]),
                    .p     (grp_p[g]),
                    .c_msb (c_into_msb)
                );
            end else begin : g_mid
                logic c_msb_unused;
                cla_group #(.BLOCK(BLOCK)) u_grp (
                    .a     (op_a[g*BLOCK +: BLOCK]),
                    .b     (op_b[g*BLOCK +: BLOCK]),
                    .ci    (grp_c[g]),
                    .s     (op_s[g*BLOCK +: BLOCK]),
                    .g     (grp_g[g]),
                    .p     (grp_p[g]),
                    .c_msb (c_msb_unused)
                );
            end
        end

        // Second-level lookahead across this stage's groups.
        always_comb begin
            grp_c = '0;
            for (int g = 0; g <= NG; g++) begin
                grp_c[g] = lookahead_carry(LA_W'(grp_g), LA_W'(grp_p), c_in, g);
            end
        end

        always_comb begin
            sum_d          = sum_prev;
            sum_d[HI-1:LO] = op_s;
            ctrl_d         = '0;
            ctrl_d.valid   = v_in;
            ctrl_d.carry   = grp_c[NG];
`ifdef CLA_ADDER_SUB_EN
            ctrl_d.sub     = flip;
`endif
        end

        // NOTE: data registers are reset too, so the outputs read 0 out of reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ctrl_q[k] <= '0;
                sum_q[k]  <= '0;
            end else if (adv[k]) begin
                ctrl_q[k] <= ctrl_d;
                sum_q[k]  <= sum_d;
            end
        end

        if (k < NSTAGE - 1) begin : g_skew
            logic [WIDTH-1:OP_LO] nxt_a;
            logic [WIDTH-1:OP_LO] nxt_b;
            if (k == 0) begin : g_from_port
                assign nxt_a = a[WIDTH-1:OP_LO];
                assign nxt_b = b[WIDTH-1:OP_LO];
            end else begin : g_from_prev
                assign nxt_a = a_q[k-1];
                assign nxt_b = b_q[k-1];
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q[k] <= '0;
                    b_q[k] <= '0;
                end else if (adv[k]) begin
                    a_q[k] <= nxt_a;
                    b_q[k] <= nxt_b;
                end
            end
        end else begin : g_of
            // Overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)         of_q <= 1'b0;
                else if (adv[k]) of_q <= c_into_msb ^ grp_c[NG];
            end
        end
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_adder_pipe
// Self-checking bench for cla_adder_pipe at WIDTH=8, BLOCK=4,
// GROUPS_PER_STAGE=1 (two stages). A queue of expected results, computed with
// plain integer arithmetic at acceptance time, is compared against every
// result the DUT presents. Directed vectors also carry literal expectations.
// Subtraction vectors run when CLA_ADDER_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_cla_adder_pipe;

    localparam int W      = 8;
    localparam int NSTAGE = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         co;
    logic         of;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit nostall  = 1'b1;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         of;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_adder_pipe #(.WIDTH(W), .BLOCK(4), .GROUPS_PER_STAGE(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef CLA_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .of        (of)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference: integer add/subtract, overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic sb, input int at);
        exp_t e;
        int   total;
        if (sb) begin
            total = int'(x) - int'(y);
            e.s   = W'(total);
            e.co  = (x >= y);
            e.of  = (x[W-1] != y[W-1]) && (e.s[W-1] != x[W-1]);
        end else begin
            total = int'(x) + int'(y) + int'(c);
            e.s   = W'(total);
            e.co  = (total > 255);
            e.of  = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
        end
        e.cyc = at;
        return e;
    endfunction

    // Compare process: every presented result is checked against the queue.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("model s",  32'(s),  32'(exp_q[0].s));
                    check("model co", 32'(co), 32'(exp_q[0].co));
                    check("model of", 32'(of), 32'(exp_q[0].of));
                    if (nostall) check("latency", 32'(cyc - exp_q[0].cyc), 32'(NSTAGE));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, ci, sub, cyc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic sb);
        bit took;
        took = 1'b0;
        a = x; b = y; ci = c; sub = sb; in_valid = 1'b1;
        for (int t = 0; t < 20 && !took; t++) begin
            @(negedge clk);
            took = in_ready;
            step();
        end
        in_valid = 1'b0;
        check("send accepted", 32'(took), 32'd1);
    endtask

    task automatic expect_result(input string name, input logic [W-1:0] es,
                                 input logic eco, input logic eof);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, " valid"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, " s"},  32'(s),  32'(es));
            check({name, " co"}, 32'(co), 32'(eco));
            check({name, " of"}, 32'(of), 32'(eof));
        end
        step();
    endtask

    task automatic drain();
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drained", 32'(exp_q.size()), 32'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset s",         32'(s),         32'd0);
        check("reset co",        32'(co),        32'd0);
        check("reset of",        32'(of),        32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready after reset", 32'(in_ready), 32'd1);
        step();

        // Directed carry/overflow corners.
        send(8'h7F, 8'h01, 1'b0, 1'b0); expect_result("7F+01",    8'h80, 1'b0, 1'b1);
        send(8'hFF, 8'h01, 1'b0, 1'b0); expect_result("FF+01",    8'h00, 1'b1, 1'b0);
        send(8'h80, 8'h80, 1'b1, 1'b0); expect_result("80+80+1",  8'h01, 1'b1, 1'b1);

        // 16 back-to-back beats at full throughput.
        for (int i = 0; i < 16; i++) begin
            a = W'(i); b = W'(3 * i); ci = i[0]; sub = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            check("stream in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        drain();

        // Backpressure: output held for 5 cycles, then released.
        nostall   = 1'b0;
        out_ready = 1'b0;
        j = 0;
        for (int t = 0; t < 5; t++) begin
            a = W'(j * 37 + 5); b = W'(j * 91 + 200); ci = j[0]; in_valid = 1'b1;
            @(negedge clk);
            check("bp in_ready", 32'(in_ready), (j < NSTAGE) ? 32'd1 : 32'd0);
            if (in_ready) j++;
            step();
        end
        check("bp out_valid held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int t = 0; t < 30 && j < 6; t++) begin
            a = W'(j * 37 + 5); b = W'(j * 91 + 200); ci = j[0]; in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) j++;
            step();
        end
        in_valid = 1'b0;
        check("bp beats accepted", 32'(j), 32'd6);
        drain();

        // Reset with two beats in flight.
        nostall = 1'b1;
        a = 8'h11; b = 8'h22; ci = 1'b0; in_valid = 1'b1;
        @(negedge clk); step();
        a = 8'h33; b = 8'h44;
        @(negedge clk); step();
        in_valid = 1'b0;
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset s",         32'(s),         32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("no stale result", 32'(out_valid), 32'd0);
            step();
        end
        send(8'h12, 8'h34, 1'b1, 1'b0); expect_result("post-reset 12+34+1", 8'h47, 1'b0, 1'b0);

`ifdef CLA_ADDER_SUB_EN
        send(8'h05, 8'h07, 1'b0, 1'b1); expect_result("05-07", 8'hFE, 1'b0, 1'b0);
        send(8'h80, 8'h01, 1'b1, 1'b1); expect_result("80-01", 8'h7F, 1'b1, 1'b1);
`endif

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
Parametrised, pipelined carry-lookahead adder, the successor to the fixed 8-bit two-group CLA.
- Operand width is WIDTH. The adder splits into BLOCK-bit lookahead groups, and GROUPS_PER_STAGE groups are evaluated per pipeline stage.
- The carry is registered between stages.
- Valid/ready handshakes on input and output give one result per cycle at full throughput, with lossless backpressure.
- Used as the arithmetic core wherever the datapath needs WIDTH-bit add with carry and signed overflow at high clock rate.

Parameters:
- WIDTH, 32, operand/sum width. Must be a multiple of BLOCK.
- BLOCK, 4, bits per lookahead group. Legal values are 2, 4, 8.
- GROUPS_PER_STAGE, 2, lookahead groups evaluated per pipeline stage. NSTAGE = ceil(WIDTH / (BLOCK*GROUPS_PER_STAGE)).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  adder accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry in
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum
- co  out  1  carry out of MSB
- of  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async assert, released synchronously by clk): all stage valid bits cleared.
  - out_valid=0, s=0, co=0, of=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Data registers are also cleared to 0.
- Stage k (0..NSTAGE-1):
  - Computes sum bits [k*SW +: SW], where SW = BLOCK*GROUPS_PER_STAGE. The last stage is truncated if WIDTH is not a multiple of SW.
  - Each group takes gi=ai&bi and pi=ai^bi and produces full-lookahead carries inside the group.
  - Group generate/propagate are combined with a second-level lookahead across the stage's groups, so there is no ripple between groups inside a stage.
  - Carry into stage k+1 is registered.
  - Unconsumed upper operand bits and already-computed lower sum bits travel in skew registers alongside.
- Latency: exactly NSTAGE cycles from the accepting edge (in_valid & in_ready) to out_valid=1, with no stall.
- Throughput: one beat per cycle when out_ready is held high.
- Stall rules:
  - Stage k advances when its valid is 0 or stage k+1 advances. The last stage advances when out_ready=1 or out_valid=0.
  - in_ready = stage-0 advance condition.
  - A stalled stage holds all of its data bits unchanged.
- Results leave in acceptance order. No beat is lost or duplicated.
- s/co/of are stable while out_valid=1 and out_ready=0.
- Simultaneous accept and emit on the same edge is legal with no bubble.
- Reset mid-stream: all in-flight beats are discarded, with no partial result emitted.
- of is computed only in the final stage, from the carry into bit WIDTH-1 and co.
- in_valid may deassert freely. Operand values are don't-care when in_valid=0.

Optional Feature:
- Macro: CLA_ADDER_SUB_EN.
- With the macro defined:
  - Extra input port sub (1 bit).
  - When sub=1 at acceptance, b is replaced by ~b and the effective carry-in is forced to 1 (ci ignored), giving a-b.
  - co=1 means no borrow. of is signed subtraction overflow.
  - sub is sampled with the beat and travels with it.
- Without the macro: no sub port, and the adder performs addition only.

Decomposition:
- Package cla_pkg holds:
  - the function computing NSTAGE from WIDTH/BLOCK/GROUPS_PER_STAGE;
  - a packed struct for one stage's pipeline register: valid, carry, partial sum, remaining a/b, sub flag under the macro.
- One sub-module, cla_group: combinational BLOCK-bit lookahead group.
  - Inputs a, b, ci.
  - Outputs s, group generate G, group propagate P, and carry into the group MSB, so the top group can form of.
  - Instantiated NSTAGE*GROUPS_PER_STAGE times by generate loop.

Test Plan (WIDTH=8, BLOCK=4, GROUPS_PER_STAGE=1, so NSTAGE=2):
- a=0x7F, b=0x01, ci=0 -> after 2 cycles: s=0x80, co=0, of=1.
- a=0xFF, b=0x01, ci=0 -> s=0x00, co=1, of=0. Also a=0x80, b=0x80, ci=1 -> s=0x01, co=1, of=1.
- Stream 16 back-to-back beats (a=i, b=3*i, ci=i[0]) with out_ready=1:
  - in_ready is constant 1;
  - results emerge consecutively starting cycle 2, each equal to a+b+ci mod 256.
- Stream with out_ready held 0 for 5 cycles:
  - in_ready drops after 2 beats are held;
  - out data stable;
  - on release, all beats emerge in order with none lost.
- Assert rst with 2 beats in flight -> out_valid=0 immediately (async). After release, no stale result appears and the next beat computes correctly.
- With CLA_ADDER_SUB_EN: sub=1, a=0x05, b=0x07 -> s=0xFE, co=0, of=0. sub=1, a=0x80, b=0x01 -> s=0x7F, co=1, of=1.
